// File: rtl/tel_pkg.sv
// Shared types and constants for the telemetry readout sequencer.
// TEL_CHECKSUM_EN (in tel_readout_seq) appends a 16-bit checksum word to each frame.
package tel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_CNT  = 3'd2,
        ST_RD   = 3'd3,
        ST_CAP  = 3'd4,
        ST_XFER = 3'd5,
        ST_SUM  = 3'd6
    } tel_state_e;

    localparam logic [15:0] HEADER_WORD_DEF = 16'hEB90;
    localparam logic [7:0]  FIRST_ADDR_DEF  = 8'h19;
    localparam logic [7:0]  LAST_ADDR_DEF   = 8'h3B;

    localparam int MON_WORDS         = int'(LAST_ADDR_DEF) - int'(FIRST_ADDR_DEF) + 1;
    localparam int FRAME_WORDS_PLAIN = MON_WORDS + 2;
    localparam int FRAME_WORDS_SUM   = MON_WORDS + 3;

    // Frame checksum is a plain modulo-2^16 sum of count word and monitor words.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/tel_period_timer.sv
// Free-running request timer: counts 0..PERIOD_CYC-1 while enabled and
// flags the wrap cycle; disabling holds the count at zero.
module tel_period_timer #(
    parameter int PERIOD_CYC = 50_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic tick_en_in,
    output logic wrap_out
);

    localparam int            CW       = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CYC - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Period counter, cleared by reset or when the timer is disabled.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_r <= '0;
        end else if (!tick_en_in) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + ONE_CNT;
        end
    end

    assign wrap_out = tick_en_in && (cnt_r == LAST_CNT);

endmodule

// File: rtl/tel_readout_seq.sv
// Telemetry readout sequencer: walks the monitor window and streams one framed packet
// per granted request. Define TEL_CHECKSUM_EN to append a checksum word to each frame.
module tel_readout_seq
    import tel_pkg::*;
#(
    parameter int          PERIOD_CYC  = 50_000_000,
    parameter logic [7:0]  FIRST_ADDR  = FIRST_ADDR_DEF,
    parameter logic [7:0]  LAST_ADDR   = LAST_ADDR_DEF,
    parameter logic [15:0] HEADER_WORD = HEADER_WORD_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tick_en_in,
    input  logic        cmd_req_in,
    output logic        mon_rd_out,
    output logic [7:0]  mon_addr_out,
    input  logic [15:0] mon_data_in,
    output logic [15:0] tel_data_out,
    output logic        tel_valid_out,
    input  logic        tel_ready_in,
    output logic        tel_sof_out,
    output logic        tel_eof_out,
    output logic        busy_out,
    output logic [15:0] frame_cnt_out,
    output logic [7:0]  drop_cnt_out
);

    tel_state_e  state_r;
    logic        pend_tmr_r, pend_cmd_r;
    logic [7:0]  drop_cnt_r;
    logic [15:0] frame_cnt_r;
    logic        mon_rd_r, tel_valid_r, tel_sof_r, tel_eof_r, busy_r;
    logic [7:0]  mon_addr_r;
    logic [15:0] tel_data_r;
`ifdef TEL_CHECKSUM_EN
    logic [15:0] sum_r;
`endif

    logic       timer_wrap_s, start_s, xfer_s;
    logic [1:0] drop_inc_s;
    logic [8:0] drop_sum_s;
    logic [7:0] drop_next_s;

    tel_period_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .tick_en_in (tick_en_in),
        .wrap_out   (timer_wrap_s)
    );

    // Grant, handshake and saturating drop accounting.
    always_comb begin
        start_s    = (state_r == ST_IDLE) && (pend_tmr_r || pend_cmd_r);
        xfer_s     = tel_valid_r && tel_ready_in;
        drop_inc_s = {1'b0, timer_wrap_s && pend_tmr_r && !start_s}
                   + {1'b0, cmd_req_in && pend_cmd_r && !start_s};
        drop_sum_s = {1'b0, drop_cnt_r} + {7'b0000000, drop_inc_s};
        if (drop_sum_s[8]) begin
            drop_next_s = 8'hFF;
        end else begin
            drop_next_s = drop_sum_s[7:0];
        end
    end

    // One-deep pending flags; a grant clears both, a same-cycle request re-arms its flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_tmr_r <= 1'b0;
            pend_cmd_r <= 1'b0;
            drop_cnt_r <= 8'h00;
        end else begin
            pend_tmr_r <= timer_wrap_s || (pend_tmr_r && !start_s);
            pend_cmd_r <= cmd_req_in || (pend_cmd_r && !start_s);
            drop_cnt_r <= drop_next_s;
        end
    end

    // Frame sequencer with registered stream and monitor-port outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= ST_IDLE;
            mon_rd_r    <= 1'b0;
            mon_addr_r  <= 8'h00;
            tel_data_r  <= 16'h0000;
            tel_valid_r <= 1'b0;
            tel_sof_r   <= 1'b0;
            tel_eof_r   <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= 16'h0000;
`ifdef TEL_CHECKSUM_EN
            sum_r       <= 16'h0000;
`endif
        end else begin
            case (state_r)
                ST_IDLE: if (start_s) begin
                    tel_data_r  <= HEADER_WORD;
                    tel_valid_r <= 1'b1;
                    tel_sof_r   <= 1'b1;
                    busy_r      <= 1'b1;
                    state_r     <= ST_HDR;
                end
                ST_HDR: if (xfer_s) begin
                    tel_data_r <= frame_cnt_r;
                    tel_sof_r  <= 1'b0;
`ifdef TEL_CHECKSUM_EN
                    sum_r      <= frame_cnt_r;
`endif
                    state_r    <= ST_CNT;
                end
                ST_CNT: if (xfer_s) begin
                    tel_valid_r <= 1'b0;
                    mon_rd_r    <= 1'b1;
                    mon_addr_r  <= FIRST_ADDR;
                    state_r     <= ST_RD;
                end
                ST_RD: begin
                    mon_rd_r <= 1'b0;
                    state_r  <= ST_CAP;
                end
                ST_CAP: begin
                    tel_data_r  <= mon_data_in;
                    tel_valid_r <= 1'b1;
`ifdef TEL_CHECKSUM_EN
                    sum_r       <= csum_add(sum_r, mon_data_in);
                    tel_eof_r   <= 1'b0;
`else
                    tel_eof_r   <= (mon_addr_r == LAST_ADDR);
`endif
                    state_r     <= ST_XFER;
                end
                ST_XFER: if (xfer_s) begin
                    if (mon_addr_r == LAST_ADDR) begin
`ifdef TEL_CHECKSUM_EN
                        tel_data_r  <= sum_r;
                        tel_eof_r   <= 1'b1;
                        state_r     <= ST_SUM;
`else
                        tel_valid_r <= 1'b0;
                        tel_eof_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        state_r     <= ST_IDLE;
`endif
                    end else begin
                        tel_valid_r <= 1'b0;
                        mon_rd_r    <= 1'b1;
                        mon_addr_r  <= mon_addr_r + 8'd1;
                        state_r     <= ST_RD;
                    end
                end
`ifdef TEL_CHECKSUM_EN
                ST_SUM: if (xfer_s) begin
                    tel_valid_r <= 1'b0;
                    tel_eof_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                    state_r     <= ST_IDLE;
                end
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign mon_rd_out    = mon_rd_r;
    assign mon_addr_out  = mon_addr_r;
    assign tel_data_out  = tel_data_r;
    assign tel_valid_out = tel_valid_r;
    assign tel_sof_out   = tel_sof_r;
    assign tel_eof_out   = tel_eof_r;
    assign busy_out      = busy_r;
    assign frame_cnt_out = frame_cnt_r;
    assign drop_cnt_out  = drop_cnt_r;

endmodule

// File: tb/tb_tel_readout_seq.sv
// Scoreboard bench for tel_readout_seq; honours TEL_CHECKSUM_EN for the frame layout.
module tb_tel_readout_seq;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        tick_en_in = 1'b0;
    logic        cmd_req_in = 1'b0;
    logic        mon_rd_out;
    logic [7:0]  mon_addr_out;
    logic [15:0] mon_data_in = 16'h0000;
    logic [15:0] tel_data_out;
    logic        tel_valid_out;
    logic        tel_ready_in = 1'b1;
    logic        tel_sof_out, tel_eof_out, busy_out;
    logic [15:0] frame_cnt_out;
    logic [7:0]  drop_cnt_out;

    tel_readout_seq #(.PERIOD_CYC(200)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tick_en_in(tick_en_in), .cmd_req_in(cmd_req_in),
        .mon_rd_out(mon_rd_out), .mon_addr_out(mon_addr_out), .mon_data_in(mon_data_in),
        .tel_data_out(tel_data_out), .tel_valid_out(tel_valid_out), .tel_ready_in(tel_ready_in),
        .tel_sof_out(tel_sof_out), .tel_eof_out(tel_eof_out), .busy_out(busy_out),
        .frame_cnt_out(frame_cnt_out), .drop_cnt_out(drop_cnt_out)
    );

    always #10 clk_in = ~clk_in;

    // Monitor model: returns 0x1000+addr the cycle after a read strobe.
    always @(posedge clk_in)
        mon_data_in <= mon_rd_out ? (16'h1000 + {8'h00, mon_addr_out}) : 16'hDEAD;

`ifdef TEL_CHECKSUM_EN
    localparam int EXP_SPAN = 107;
`else
    localparam int EXP_SPAN = 106;
`endif

    int checks = 0;
    int errors = 0;
    logic [17:0] sb[$];
    int frames_seen = 0;
    int word_idx = 0;
    int rd_cnt = 0;
    int cyc = 0;
    int sof_cyc = 0;
    bit mon_en = 1'b0;
    bit tput_en = 1'b1;
    bit rand_ready = 1'b0;
    bit prev_rd = 1'b0;
    bit stall_prev = 1'b0;
    logic [17:0] stall_word = 18'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] cnt);
        logic [15:0] sum;
        logic [15:0] d;
        sb.push_back({1'b1, 1'b0, 16'hEB90});
        sb.push_back({1'b0, 1'b0, cnt});
        sum = cnt;
        for (int a = 8'h19; a <= 8'h3B; a++) begin
            d = 16'h1000 + 16'(a);
            sum = sum + d;
`ifdef TEL_CHECKSUM_EN
            sb.push_back({1'b0, 1'b0, d});
`else
            sb.push_back({1'b0, (a == 8'h3B), d});
`endif
        end
`ifdef TEL_CHECKSUM_EN
        sb.push_back({1'b0, 1'b1, sum});
`endif
    endtask

    task automatic pulse_cmd();
        cmd_req_in = 1'b1;
        @(posedge clk_in); #1;
        cmd_req_in = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_seen < target; i++) @(negedge clk_in);
        chk("frames_done", 32'(frames_seen), 32'(target));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(tel_valid_out), 32'd0);
        chk({tag, "_data"},  32'(tel_data_out),  32'd0);
        chk({tag, "_sof"},   32'(tel_sof_out),   32'd0);
        chk({tag, "_eof"},   32'(tel_eof_out),   32'd0);
        chk({tag, "_rd"},    32'(mon_rd_out),    32'd0);
        chk({tag, "_addr"},  32'(mon_addr_out),  32'd0);
        chk({tag, "_busy"},  32'(busy_out),      32'd0);
        chk({tag, "_fcnt"},  32'(frame_cnt_out), 32'd0);
        chk({tag, "_drop"},  32'(drop_cnt_out),  32'd0);
    endtask

    // Random sink backpressure, about 30% not-ready.
    initial forever begin
        @(posedge clk_in); #1;
        if (rand_ready) tel_ready_in = ($urandom_range(99) >= 30);
    end

    // Stream and monitor-port checker: scoreboard pops, stall stability, strobe walk.
    initial forever begin
        @(negedge clk_in);
        cyc++;
        if (!mon_en) begin
            word_idx = 0; rd_cnt = 0; stall_prev = 1'b0; prev_rd = mon_rd_out;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(tel_valid_out), 32'd1);
                chk("stall_word", 32'({tel_sof_out, tel_eof_out, tel_data_out}), 32'(stall_word));
            end
            if (mon_rd_out) begin
                chk("rd_addr", 32'(mon_addr_out), 32'h19 + 32'(rd_cnt));
                if (rd_cnt == 0) chk("rd_rise", 32'(prev_rd), 32'd0);
                rd_cnt++;
            end
            prev_rd = mon_rd_out;
            if (tel_valid_out && tel_ready_in) begin
                if (sb.size() == 0) begin
                    chk("sb_size", 32'(sb.size()), 32'd1);
                end else begin
                    chk("word", 32'({tel_sof_out, tel_eof_out, tel_data_out}), 32'(sb.pop_front()));
                end
                if (tel_sof_out) begin
                    sof_cyc = cyc;
                    word_idx = 0;
                end
                word_idx++;
                if (tel_eof_out) begin
                    frames_seen++;
                    chk("rd_pulses", 32'(rd_cnt), 32'd35);
                    if (tput_en) chk("frame_span", 32'(cyc - sof_cyc), 32'(EXP_SPAN));
                    rd_cnt = 0;
                    word_idx = 0;
                end
            end
            stall_prev = tel_valid_out && !tel_ready_in;
            stall_word = {tel_sof_out, tel_eof_out, tel_data_out};
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk_zero_outputs("reset");
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        mon_en = 1'b1;

        // Single command frame with header latency
        push_frame(16'h0000);
        pulse_cmd();
        @(negedge clk_in);
        chk("hdr_not_yet", 32'(tel_valid_out), 32'd0);
        @(negedge clk_in);
        chk("hdr_valid", 32'(tel_valid_out), 32'd1);
        chk("hdr_sof", 32'(tel_sof_out), 32'd1);
        chk("hdr_busy", 32'(busy_out), 32'd1);
        wait_frames(1, 400);
        @(negedge clk_in);
        chk("t1_fcnt", 32'(frame_cnt_out), 32'd1);
        chk("t1_busy", 32'(busy_out), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Command and timer wrap in the same cycle merge into one frame
        @(posedge clk_in); #1;
        push_frame(16'h0001);
        tick_en_in = 1'b1;
        repeat (199) @(posedge clk_in);
        #1;
        cmd_req_in = 1'b1;
        @(posedge clk_in); #1;
        cmd_req_in = 1'b0;
        tick_en_in = 1'b0;
        wait_frames(2, 400);
        repeat (200) @(negedge clk_in);
        chk("merge_frames", 32'(frames_seen), 32'd2);
        chk("merge_drop", 32'(drop_cnt_out), 32'd0);
        chk("merge_fcnt", 32'(frame_cnt_out), 32'd2);

        // Three requests during one frame: one extra frame, one drop
        @(posedge clk_in); #1;
        push_frame(16'h0002);
        push_frame(16'h0003);
        pulse_cmd();
        repeat (10) @(posedge clk_in);
        #1;
        pulse_cmd();
        repeat (10) @(posedge clk_in);
        #1;
        pulse_cmd();
        @(negedge clk_in);
        chk("drop_busy", 32'(busy_out), 32'd1);
        wait_frames(4, 600);
        repeat (150) @(negedge clk_in);
        chk("drop_frames", 32'(frames_seen), 32'd4);
        chk("drop_cnt", 32'(drop_cnt_out), 32'd1);
        chk("drop_fcnt", 32'(frame_cnt_out), 32'd4);

        // Random backpressure
        @(posedge clk_in); #1;
        tput_en = 1'b0;
        rand_ready = 1'b1;
        push_frame(16'h0004);
        pulse_cmd();
        wait_frames(5, 2000);
        rand_ready = 1'b0;
        @(posedge clk_in); #2;
        tel_ready_in = 1'b1;
        @(negedge clk_in);
        chk("bp_fcnt", 32'(frame_cnt_out), 32'd5);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        tput_en = 1'b1;

        // Reset at word 20 aborts the frame
        @(posedge clk_in); #1;
        push_frame(16'h0005);
        pulse_cmd();
        for (int i = 0; i < 300 && word_idx < 20; i++) @(negedge clk_in);
        chk("reach_word20", 32'(word_idx), 32'd20);
        @(posedge clk_in); #1;
        mon_en = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_zero_outputs("midrst");
        sb.delete();
        @(posedge clk_in); #1;
        mon_en = 1'b1;
        push_frame(16'h0000);
        pulse_cmd();
        wait_frames(6, 400);
        @(negedge clk_in);
        chk("post_rst_fcnt", 32'(frame_cnt_out), 32'd1);

        // Periodic timer: 1000 enabled cycles at period 200 give 5 frames
        @(posedge clk_in); #1;
        for (int k = 1; k <= 5; k++) push_frame(16'(k));
        tick_en_in = 1'b1;
        repeat (1000) @(posedge clk_in);
        #1;
        tick_en_in = 1'b0;
        wait_frames(11, 600);
        repeat (600) @(negedge clk_in);
        chk("tmr_frames", 32'(frames_seen), 32'd11);
        chk("tmr_fcnt", 32'(frame_cnt_out), 32'd6);
        chk("tmr_drop", 32'(drop_cnt_out), 32'd0);
        chk("tmr_sb_empty", 32'(sb.size()), 32'd0);
        chk("tmr_busy", 32'(busy_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
